// File: rtl/freq_divider_prog_if.sv
// Divisor write bus for freq_divider_prog: write strobe, channel, value, reject pulse and per-channel pending flags.
interface freq_divider_prog_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic             wr_err;
  logic [N_CH-1:0]  pending;

  modport master (output wr_en, wr_ch, wr_div, input wr_err, pending);
  modport slave  (input wr_en, wr_ch, wr_div, output wr_err, pending);
endinterface

// File: rtl/freq_divider_prog.sv
// Multi-channel programmable clock divider; divisor writes are shadowed and applied at period boundaries.
// Optional macro SYNC_START_EN adds a sync_start input that phase-aligns every channel.
module freq_divider_prog #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_en,
`ifdef SYNC_START_EN
  input  logic              sync_start,
`endif
  freq_divider_prog_if.slave wr_bus,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  localparam logic [4:0]       N_CH_LIM = 5'(N_CH);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN  = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  logic wr_valid;
  logic wr_ok;
  logic wr_rej;
  logic sync_pulse;
  logic wr_err_reg;

  assign wr_valid = ({1'b0, wr_bus.wr_ch} < N_CH_LIM) && (wr_bus.wr_div >= DIV_MIN);
  assign wr_ok    = wr_bus.wr_en && wr_valid;
  assign wr_rej   = wr_bus.wr_en && !wr_valid;

`ifdef SYNC_START_EN
  assign sync_pulse = sync_start;
`else
  assign sync_pulse = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_rej;
    end
  end

  assign wr_bus.wr_err = wr_err_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [3:0] CH_ID = 4'(gi);

    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic             pending_reg;
    logic             clk_reg;
    logic             tick_reg;
    logic             wr_hit;
    logic             at_wrap;
    logic             restart;
    logic [WIDTH:0]   high_len;

    assign wr_hit   = wr_ok && (wr_bus.wr_ch == CH_ID);
    assign at_wrap  = (cnt_reg == div_reg - ONE_W);
    assign restart  = sync_pulse || !ch_en[gi];
    // Widened by one bit so (div+1)/2 cannot overflow at the largest divisor.
    assign high_len = ({1'b0, div_reg} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

    always_ff @(posedge clk_in) begin
      if (reset) begin
        div_reg     <= DIV_RST;
        cnt_reg     <= '0;
        shadow_reg  <= '0;
        pending_reg <= 1'b0;
        clk_reg     <= 1'b0;
        tick_reg    <= 1'b0;
      end else begin
        // Divisor changes only where a period ends or the channel is parked, so no runt pulses.
        if (restart || at_wrap) begin
          cnt_reg <= '0;
          if (pending_reg) begin
            div_reg <= shadow_reg;
          end
          pending_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg + ONE_W;
        end

        if (restart) begin
          clk_reg  <= 1'b0;
          tick_reg <= 1'b0;
        end else begin
          clk_reg  <= ({1'b0, cnt_reg} < high_len);
          tick_reg <= at_wrap;
        end

        // A write landing in the apply cycle stays queued as the next pending divisor.
        if (wr_hit) begin
          shadow_reg  <= wr_bus.wr_div;
          pending_reg <= 1'b1;
        end
      end
    end

    assign clk_out[gi]        = clk_reg;
    assign tick[gi]           = tick_reg;
    assign wr_bus.pending[gi] = pending_reg;
  end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Randomized and directed bench for freq_divider_prog against a period-level channel model.
module tb_freq_divider_prog;
  localparam int N_CH        = 4;
  localparam int WIDTH       = 16;
  localparam int DEFAULT_DIV = 2;

  logic            clk_in = 1'b0;
  logic            reset  = 1'b1;
  logic [N_CH-1:0] ch_en  = '0;
`ifdef SYNC_START_EN
  logic            sync_start = 1'b0;
`endif
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] tick;

  freq_divider_prog_if #(.N_CH(N_CH), .WIDTH(WIDTH)) wr_bus ();

  freq_divider_prog #(.N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .ch_en      (ch_en),
`ifdef SYNC_START_EN
    .sync_start (sync_start),
`endif
    .wr_bus     (wr_bus),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: each channel is a position inside its current period plus the divisor of that period.
  int m_div[N_CH];
  int m_pos[N_CH];
  int m_shadow[N_CH];
  bit m_pend[N_CH];
  logic [N_CH-1:0] exp_clk, exp_tick, exp_pend;
  logic            exp_err;

  task automatic model_update();
    bit s;
    bit acc;
    int wc;
    int wd;
    s = 1'b0;
`ifdef SYNC_START_EN
    s = sync_start;
`endif
    wc  = int'(wr_bus.wr_ch);
    wd  = int'(wr_bus.wr_div);
    acc = wr_bus.wr_en && (wc < N_CH) && (wd >= 2);
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_div[i] = DEFAULT_DIV; m_pos[i] = 0; m_shadow[i] = 0; m_pend[i] = 1'b0;
      end
      exp_clk = '0; exp_tick = '0; exp_pend = '0; exp_err = 1'b0;
      return;
    end
    exp_err = wr_bus.wr_en && !acc;
    for (int i = 0; i < N_CH; i++) begin
      bit boundary;
      if (s || !ch_en[i]) begin
        exp_clk[i] = 1'b0; exp_tick[i] = 1'b0; m_pos[i] = 0; boundary = 1'b1;
      end else begin
        exp_clk[i]  = (m_pos[i] < (m_div[i] + 1) / 2);
        exp_tick[i] = (m_pos[i] == m_div[i] - 1);
        boundary    = exp_tick[i];
        m_pos[i]    = boundary ? 0 : m_pos[i] + 1;
      end
      if (boundary && m_pend[i]) begin
        m_div[i] = m_shadow[i]; m_pend[i] = 1'b0;
      end
      if (acc && wc == i) begin
        m_shadow[i] = wd; m_pend[i] = 1'b1;
      end
      exp_pend[i] = m_pend[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_en = '1;
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 4'd0; wr_bus.wr_div = 16'd7;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if ({wr_bus.wr_err, wr_bus.pending, tick, clk_out} !== 13'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got err=%b pend=%b tick=%b clk=%b want all zero",
                 cyc, wr_bus.wr_err, wr_bus.pending, tick, clk_out);
      end
    end
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic test_default();
    logic [7:0] want;
    reset = 1'b0; ch_en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cycle();
      want = {3'b000, k[0], 3'b000, ~k[0]};
      checks++;
      if ({tick, clk_out} !== want) begin
        errors++;
        $display("FAIL default_div2 cyc=%0d got tick=%b clk=%b want tick=%b clk=%b",
                 cyc, tick, clk_out, want[7:4], want[3:0]);
      end
    end
  endtask

  task automatic test_write_mid();
    int highs;
    int ticks;
    int n;
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 4'd0; wr_bus.wr_div = 16'd5;
    cycle();
    wr_bus.wr_en = 1'b0;
    checks++;
    if (wr_bus.pending !== exp_pend || wr_bus.pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_pending cyc=%0d got pend=%b want pend=%b", cyc, wr_bus.pending, exp_pend);
    end
    for (n = 0; n < 10 && wr_bus.pending[0]; n++) cycle();
    checks++;
    if (wr_bus.pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_apply_timeout cyc=%0d got pend0=%b want 0", cyc, wr_bus.pending[0]);
    end
    highs = 0; ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      highs += int'(clk_out[0]); ticks += int'(tick[0]);
      checks++;
      if ({wr_bus.wr_err, wr_bus.pending, tick, clk_out} !== {exp_err, exp_pend, exp_tick, exp_clk}) begin
        errors++;
        $display("FAIL div5_model cyc=%0d got tick=%b clk=%b want tick=%b clk=%b",
                 cyc, tick, clk_out, exp_tick, exp_clk);
      end
    end
    checks++;
    if (highs != 6 || ticks != 2) begin
      errors++;
      $display("FAIL div5_shape got highs=%0d ticks=%0d want highs=6 ticks=2", highs, ticks);
    end
  endtask

  task automatic test_reject();
    logic [N_CH-1:0] pend_before;
    pend_before = wr_bus.pending;
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 4'd0; wr_bus.wr_div = 16'd1;
    cycle();
    checks++;
    if (wr_bus.wr_err !== 1'b1 || wr_bus.pending !== pend_before) begin
      errors++;
      $display("FAIL reject_div1 cyc=%0d got err=%b pend=%b want err=1 pend=%b",
               cyc, wr_bus.wr_err, wr_bus.pending, pend_before);
    end
    wr_bus.wr_ch = 4'd7; wr_bus.wr_div = 16'd5;
    cycle();
    checks++;
    if (wr_bus.wr_err !== 1'b1 || wr_bus.pending !== pend_before) begin
      errors++;
      $display("FAIL reject_ch7 cyc=%0d got err=%b pend=%b want err=1 pend=%b",
               cyc, wr_bus.wr_err, wr_bus.pending, pend_before);
    end
    wr_bus.wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if ({wr_bus.wr_err, wr_bus.pending, tick, clk_out} !== {exp_err, exp_pend, exp_tick, exp_clk}) begin
        errors++;
        $display("FAIL reject_after cyc=%0d got err=%b tick=%b clk=%b want err=%b tick=%b clk=%b",
                 cyc, wr_bus.wr_err, tick, clk_out, exp_err, exp_tick, exp_clk);
      end
    end
  endtask

  task automatic test_overwrite();
    int highs;
    int ticks;
    int n;
    ch_en = 4'b0011;
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 4'd1; wr_bus.wr_div = 16'd9;
    cycle();
    wr_bus.wr_en = 1'b0;
    for (n = 0; n < 6 && wr_bus.pending[1]; n++) cycle();
    wr_bus.wr_en = 1'b1; wr_bus.wr_div = 16'd10;
    cycle();
    wr_bus.wr_div = 16'd4;
    cycle();
    wr_bus.wr_en = 1'b0;
    for (n = 0; n < 14 && wr_bus.pending[1]; n++) begin
      cycle();
      checks++;
      if ({wr_bus.pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
        errors++;
        $display("FAIL overwrite_wait cyc=%0d got pend=%b tick=%b clk=%b want pend=%b tick=%b clk=%b",
                 cyc, wr_bus.pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
      end
    end
    highs = 0; ticks = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      highs += int'(clk_out[1]); ticks += int'(tick[1]);
    end
    checks++;
    if (highs != 4 || ticks != 2) begin
      errors++;
      $display("FAIL overwrite_div4 got highs=%0d ticks=%0d want highs=4 ticks=2", highs, ticks);
    end
  endtask

  task automatic test_disable();
    int n;
    ch_en = 4'b0111;
    cycle();
    for (n = 0; n < 4 && !clk_out[2]; n++) cycle();
    ch_en[2] = 1'b0;
    cycle();
    checks++;
    if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
      errors++;
      $display("FAIL disable_low cyc=%0d got clk2=%b tick2=%b want 0 0", cyc, clk_out[2], tick[2]);
    end
    for (int k = 0; k < 6; k++) cycle();
    ch_en[2] = 1'b1;
    cycle();
    checks++;
    if (clk_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL reenable_high cyc=%0d got clk2=%b want 1", cyc, clk_out[2]);
    end
  endtask

`ifdef SYNC_START_EN
  task automatic test_sync();
    int t0;
    int t1;
    ch_en = 4'b0011;
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 4'd0; wr_bus.wr_div = 16'd3;
    cycle();
    wr_bus.wr_ch = 4'd1; wr_bus.wr_div = 16'd6;
    cycle();
    wr_bus.wr_en = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      t0 += int'(tick[0]); t1 += int'(tick[1]);
      checks++;
      if ((k == 1 && clk_out[1:0] !== 2'b11) || (tick[1] && !tick[0])) begin
        errors++;
        $display("FAIL sync_align cyc=%0d k=%0d got clk=%b tick=%b", cyc, k, clk_out, tick);
      end
    end
    checks++;
    if (t0 != 4 || t1 != 2) begin
      errors++;
      $display("FAIL sync_ticks got t0=%0d t1=%0d want t0=4 t1=2", t0, t1);
    end
  endtask
`endif

  task automatic test_back_to_back();
    ch_en = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      wr_bus.wr_en  = 1'b1;
      wr_bus.wr_ch  = 4'($urandom_range(0, 4));
      wr_bus.wr_div = 16'($urandom_range(1, 7));
      cycle();
      checks++;
      if ({wr_bus.wr_err, wr_bus.pending, tick, clk_out} !== {exp_err, exp_pend, exp_tick, exp_clk}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got err=%b pend=%b tick=%b clk=%b want err=%b pend=%b tick=%b clk=%b",
                 cyc, wr_bus.wr_err, wr_bus.pending, tick, clk_out, exp_err, exp_pend, exp_tick, exp_clk);
      end
    end
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
      wr_bus.wr_en  = ($urandom_range(0, 2) == 0);
      wr_bus.wr_ch  = 4'($urandom_range(0, 5));
      wr_bus.wr_div = 16'($urandom_range(0, 9));
`ifdef SYNC_START_EN
      sync_start = ($urandom_range(0, 39) == 0);
`endif
      cycle();
      checks++;
      if ({wr_bus.wr_err, wr_bus.pending, tick, clk_out} !== {exp_err, exp_pend, exp_tick, exp_clk}) begin
        errors++;
        $display("FAIL random cyc=%0d got err=%b pend=%b tick=%b clk=%b want err=%b pend=%b tick=%b clk=%b",
                 cyc, wr_bus.wr_err, wr_bus.pending, tick, clk_out, exp_err, exp_pend, exp_tick, exp_clk);
      end
    end
    reset = 1'b0; wr_bus.wr_en = 1'b0;
`ifdef SYNC_START_EN
    sync_start = 1'b0;
`endif
  endtask

  initial begin
    wr_bus.wr_en = 1'b0; wr_bus.wr_ch = 4'd0; wr_bus.wr_div = '0;
    test_reset();
    test_default();
    test_write_mid();
    test_reject();
    test_overwrite();
    test_disable();
`ifdef SYNC_START_EN
    test_sync();
`endif
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d got no completion want finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
